// File: rtl/serial_word_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_word_deserializer                                        |
// | Purpose  : Receive end of a shift-register serial link. Samples serial_in  |
// |            on strobed cycles, assembles WIDTH-bit words (MSB- or LSB-first |
// |            chosen per word) and presents them on a valid/ready interface.  |
// | Ports    : clk, reset (async, active-high)                                 |
// |            serial_in, bit_valid, msb_first, sync   - serial side inputs    |
// |            word_ready, clr_overrun                 - consumer side inputs  |
// |            word_data[WIDTH-1:0], word_valid        - parallel word out     |
// |            overrun (sticky), bit_count[4:0]        - status                |
// |            parity_err                              - PARITY_CHECK_EN only  |
// | Config   : `define PARITY_CHECK_EN adds a trailing even-parity bit per     |
// |            word and the parity_err output.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module serial_word_deserializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             msb_first,
  input  logic             sync,
  input  logic             word_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  output logic             overrun,
`ifdef PARITY_CHECK_EN
  output logic             parity_err,
`endif
  output logic [4:0]       bit_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_PAR  = 2'd2
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);
`ifdef PARITY_CHECK_EN
  // Count reported while waiting for the parity bit (wraps to 0 for WIDTH=32).
  localparam logic [4:0] PAR_CNT  = 5'(WIDTH % 32);
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             order_q, order_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;
`endif

  logic             complete;
  logic [WIDTH-1:0] done_word;
  logic [WIDTH-1:0] shifted;
  logic             use_msb;

  // The first bit of a word uses the live msb_first; later bits use the latch.
  assign use_msb = (state_q == S_IDLE) ? msb_first : order_q;
  assign shifted = use_msb ? {sr_q[WIDTH-2:0], serial_in}
                           : {serial_in, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    order_d   = order_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
`ifdef PARITY_CHECK_EN
    perr_d    = perr_q;
`endif
    complete  = 1'b0;
    done_word = shifted;

    if (valid_q && word_ready) valid_d = 1'b0;
    if (clr_overrun)           ovr_d   = 1'b0;

    // sync dominates a coincident strobe: that bit is dropped with the partial word.
    if (sync) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      sr_d    = '0;
    end else if (bit_valid) begin
      case (state_q)
        S_IDLE: begin
          order_d = msb_first;
          sr_d    = shifted;
          cnt_d   = 5'd1;
          state_d = S_RECV;
        end
        S_RECV: begin
          sr_d = shifted;
          if (cnt_q == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
            state_d = S_PAR;
            cnt_d   = PAR_CNT;
`else
            complete = 1'b1;
            state_d  = S_IDLE;
            cnt_d    = 5'd0;
`endif
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
`ifdef PARITY_CHECK_EN
        S_PAR: begin
          complete  = 1'b1;
          done_word = sr_q;
          perr_d    = ^{sr_q, serial_in};
          state_d   = S_IDLE;
          cnt_d     = 5'd0;
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end
      endcase
    end

    // A completing word always loads; it is only an overrun if the previous
    // word is still pending and not being accepted on this same edge.
    if (complete) begin
      data_d  = done_word;
      valid_d = 1'b1;
      if (valid_q && !word_ready) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      order_q <= 1'b1;
      cnt_q   <= 5'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      order_q <= order_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign word_data  = data_q;
  assign word_valid = valid_q;
  assign overrun    = ovr_q;
  assign bit_count  = cnt_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = perr_q;
`endif

endmodule
`default_nettype wire
